// File: rtl/bsg_priority_drain_pkg.sv
// Shared types for the priority drain scheduler.
//   state_e : grant FSM state. IDLE offers the live priority-encoder result,
//             HOLD offers a frozen grant until the consumer takes it.
package bsg_priority_drain_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int default_width_lp     = 16;
   localparam int default_cnt_width_lp = 8;

endpackage

// File: rtl/bsg_priority_encode_one_hot_out.sv
// Highest-set-bit priority encoder with one-hot output.
//   i   : request vector
//   o   : one-hot of the highest-index set bit of i, zero when i is zero
//   v_o : any bit of i set
module bsg_priority_encode_one_hot_out #(
   parameter int width_p = 16
) (
   input  logic [width_p-1:0] i,
   output logic [width_p-1:0] o,
   output logic               v_o
);

   // Scan upward so the highest set bit is the last one written.
   always_comb begin
      o = '0;
      for (int k = 0; k < width_p; k++) begin
         if (i[k]) begin
            o    = '0;
            o[k] = 1'b1;
         end
      end
   end

   assign v_o = |i;

endmodule

// File: rtl/bsg_priority_drain_sched.sv
// Priority drain scheduler: gathers sticky request pulses into a pending
// vector and offers one grant at a time to a shared service port, always the
// highest-index pending source. A grant offered while the consumer stalls is
// frozen (HOLD) until taken.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   set_i            : request pulses, OR'd into pending
//   flush_i          : synchronous clear of pending, grant and counter
//   v_o, yumi_i      : grant offered / grant consumed this cycle
//   grant_oh_o       : one-hot grant, zero when v_o=0
//   grant_id_o       : binary index of grant_oh_o, zero when v_o=0
//   pending_o        : registered pending vector
//   coalesce_o       : saturating count of cycles where set_i hit an
//                      already-pending bit
// Handshake: the grant transfers on a cycle where v_o and yumi_i are both
// high; v_o and grant_oh_o depend only on registers, and a stalled grant
// never changes until it transfers. yumi_i without v_o is illegal.
module bsg_priority_drain_sched
   import bsg_priority_drain_pkg::*;
#(
   parameter int width_p     = default_width_lp,
   parameter int cnt_width_p = default_cnt_width_lp
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic [width_p-1:0]         set_i,
   input  logic                       flush_i,
   output logic                       v_o,
   output logic [width_p-1:0]         grant_oh_o,
   output logic [$clog2(width_p)-1:0] grant_id_o,
   input  logic                       yumi_i,
   output logic [width_p-1:0]         pending_o,
   output logic [cnt_width_p-1:0]     coalesce_o
);

   localparam int id_w_lp = $clog2(width_p);

   state_e                 state_r;
   logic [width_p-1:0]     pending_r;
   logic [width_p-1:0]     grant_r;
   logic [cnt_width_p-1:0] coalesce_r;

   logic [width_p-1:0]     pe_oh;
   logic                   pe_v;
   logic [width_p-1:0]     clr;
   logic                   hit;

   bsg_priority_encode_one_hot_out #(
      .width_p (width_p)
   ) u_pe (
      .i   (pending_r),
      .o   (pe_oh),
      .v_o (pe_v)
   );

   assign v_o        = (state_r == HOLD) | pe_v;
   assign grant_oh_o = (state_r == HOLD) ? grant_r : pe_oh;
   assign clr        = (yumi_i & v_o) ? grant_oh_o : '0;
   // A re-arm of the bit being consumed this cycle is not a coalesce.
   assign hit        = |(set_i & pending_r & ~clr);

   always_comb begin
      grant_id_o = '0;
      for (int k = 0; k < width_p; k++) begin
         if (grant_oh_o[k]) grant_id_o = grant_id_o | k[id_w_lp-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r    <= IDLE;
         pending_r  <= '0;
         grant_r    <= '0;
         coalesce_r <= '0;
      end else if (flush_i) begin
         state_r    <= IDLE;
         pending_r  <= '0;
         grant_r    <= '0;
         coalesce_r <= '0;
      end else begin
         // set_i applied after clr so a same-cycle re-request survives.
         pending_r <= (pending_r & ~clr) | set_i;
         if (hit && (coalesce_r != {cnt_width_p{1'b1}}))
            coalesce_r <= coalesce_r + cnt_width_p'(1);
         case (state_r)
            IDLE: begin
               if (pe_v && !yumi_i) begin
                  grant_r <= pe_oh;
                  state_r <= HOLD;
               end
            end
            HOLD: begin
               if (yumi_i) begin
                  grant_r <= '0;
                  state_r <= IDLE;
               end
            end
            default: begin
               grant_r <= '0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign pending_o  = pending_r;
   assign coalesce_o = coalesce_r;

   yumi_without_valid: assert property (
      @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
   );

endmodule

// File: tb/tb_bsg_priority_drain_sched.sv
module tb_bsg_priority_drain_sched;

   logic        clk;
   logic        reset_n;
   logic [15:0] set_i;
   logic        flush_i;
   logic        yumi_i;
   logic        v_o;
   logic [15:0] grant_oh_o;
   logic [3:0]  grant_id_o;
   logic [15:0] pending_o;
   logic [7:0]  coalesce_o;

   int errors = 0;
   int checks = 0;

   // Reference model: pending set, index of a frozen grant (-1 = none),
   // coalesce count as a plain integer.
   logic [15:0] m_pend;
   int          m_hold;
   int          m_coal;

   bsg_priority_drain_sched #(
      .width_p     (16),
      .cnt_width_p (8)
   ) dut (
      .clk_i      (clk),
      .reset_n_i  (reset_n),
      .set_i      (set_i),
      .flush_i    (flush_i),
      .v_o        (v_o),
      .grant_oh_o (grant_oh_o),
      .grant_id_o (grant_id_o),
      .yumi_i     (yumi_i),
      .pending_o  (pending_o),
      .coalesce_o (coalesce_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   function automatic int m_grant();
      if (m_hold >= 0) return m_hold;
      for (int k = 15; k >= 0; k--) if (m_pend[k]) return k;
      return -1;
   endfunction

   function automatic logic [15:0] m_oh();
      int g;
      g = m_grant();
      return (g >= 0) ? (16'h1 << g) : 16'h0;
   endfunction

   function automatic logic [3:0] m_id();
      int g;
      g = m_grant();
      return (g >= 0) ? g[3:0] : 4'h0;
   endfunction

   task automatic m_reset();
      m_pend = '0;
      m_hold = -1;
      m_coal = 0;
   endtask

   task automatic m_step(input logic [15:0] s, input logic y, input logic f);
      int          g;
      logic [15:0] c;
      g = m_grant();
      if (f) begin
         m_reset();
      end else begin
         c = (y && g >= 0) ? (16'h1 << g) : 16'h0;
         if (((s & m_pend & ~c) != 0) && m_coal < 255) m_coal++;
         m_pend = (m_pend & ~c) | s;
         if (m_hold < 0 && g >= 0 && !y) m_hold = g;
         else if (m_hold >= 0 && y) m_hold = -1;
      end
   endtask

   // ---------------- driver ----------------
   // Called at a negedge; returns at the following negedge.
   task automatic do_cycle(input logic [15:0] s, input logic y, input logic f);
      set_i   = s;
      yumi_i  = y;
      flush_i = f;
      @(posedge clk);
      m_step(s, y, f);
      @(negedge clk);
      set_i   = '0;
      yumi_i  = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      set_i   = '0;
      yumi_i  = 1'b0;
      flush_i = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      set_i   = '0;
      yumi_i  = 1'b0;
      flush_i = 1'b0;
      m_reset();
      #1;
      checks++;
      if (v_o !== 1'b0 || grant_oh_o !== 16'h0 || grant_id_o !== 4'h0) begin
         errors++;
         $display("FAIL reset_outputs: v=%b oh=%h id=%0d expected v=0 oh=0000 id=0",
                  v_o, grant_oh_o, grant_id_o);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_cycle(16'h0000, 1'b0, 1'b0);
         checks++;
         if (v_o !== 1'b0 || grant_oh_o !== 16'h0 || coalesce_o !== 8'h0) begin
            errors++;
            $display("FAIL idle_after_reset[%0d]: v=%b oh=%h coal=%h expected 0 0000 00",
                     i, v_o, grant_oh_o, coalesce_o);
         end
      end
   endtask

   task automatic test_drain_order();
      logic [15:0] exp_g [3];
      exp_g[0] = 16'h0100;
      exp_g[1] = 16'h0004;
      exp_g[2] = 16'h0001;
      do_cycle(16'h0105, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (v_o !== 1'b1 || grant_oh_o !== exp_g[i]) begin
            errors++;
            $display("FAIL drain_grant[%0d]: v=%b oh=%h expected v=1 oh=%h",
                     i, v_o, grant_oh_o, exp_g[i]);
         end
         do_cycle(16'h0000, 1'b1, 1'b0);
      end
      checks++;
      if (v_o !== 1'b0 || pending_o !== 16'h0) begin
         errors++;
         $display("FAIL drain_empty: v=%b pending=%h expected v=0 pending=0000", v_o, pending_o);
      end
   endtask

   task automatic test_hold_freeze();
      do_cycle(16'h0002, 1'b0, 1'b0);
      do_cycle(16'h8000, 1'b0, 1'b0);
      checks++;
      if (v_o !== 1'b1 || grant_oh_o !== 16'h0002 || pending_o !== 16'h8002) begin
         errors++;
         $display("FAIL hold_frozen: v=%b oh=%h pend=%h expected v=1 oh=0002 pend=8002",
                  v_o, grant_oh_o, pending_o);
      end
      do_cycle(16'h0000, 1'b0, 1'b0);
      checks++;
      if (grant_oh_o !== 16'h0002 || grant_id_o !== 4'd1) begin
         errors++;
         $display("FAIL hold_stable: oh=%h id=%0d expected oh=0002 id=1", grant_oh_o, grant_id_o);
      end
      do_cycle(16'h0000, 1'b1, 1'b0);
      checks++;
      if (v_o !== 1'b1 || grant_oh_o !== 16'h8000 || grant_id_o !== 4'd15) begin
         errors++;
         $display("FAIL hold_next: v=%b oh=%h id=%0d expected v=1 oh=8000 id=15",
                  v_o, grant_oh_o, grant_id_o);
      end
      do_cycle(16'h0000, 1'b1, 1'b0);
      checks++;
      if (v_o !== 1'b0) begin
         errors++;
         $display("FAIL hold_drained: v=%b expected 0", v_o);
      end
   endtask

   task automatic test_rearm();
      logic [7:0] coal_before;
      do_cycle(16'h0010, 1'b0, 1'b0);
      do_cycle(16'h0000, 1'b0, 1'b0);
      coal_before = 8'(m_coal);
      do_cycle(16'h0010, 1'b1, 1'b0);
      checks++;
      if (pending_o !== 16'h0010 || v_o !== 1'b1 || grant_oh_o !== 16'h0010) begin
         errors++;
         $display("FAIL rearm_pending: pend=%h v=%b oh=%h expected pend=0010 v=1 oh=0010",
                  pending_o, v_o, grant_oh_o);
      end
      checks++;
      if (coalesce_o !== coal_before) begin
         errors++;
         $display("FAIL rearm_coalesce: got %h expected %h", coalesce_o, coal_before);
      end
      do_cycle(16'h0000, 1'b1, 1'b0);
      checks++;
      if (pending_o !== 16'h0 || v_o !== 1'b0) begin
         errors++;
         $display("FAIL rearm_drained: pend=%h v=%b expected 0000 0", pending_o, v_o);
      end
   endtask

   task automatic test_saturate();
      do_cycle(16'h0000, 1'b0, 1'b1);
      do_cycle(16'h00F0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         do_cycle(16'h0030, 1'b0, 1'b0);
         if (i == 9) begin
            checks++;
            if (coalesce_o !== 8'd10) begin
               errors++;
               $display("FAIL coalesce_count: got %0d expected 10", coalesce_o);
            end
         end
      end
      checks++;
      if (coalesce_o !== 8'hFF || pending_o !== 16'h00F0 || grant_oh_o !== 16'h0080) begin
         errors++;
         $display("FAIL coalesce_saturate: coal=%h pend=%h oh=%h expected FF 00F0 0080",
                  coalesce_o, pending_o, grant_oh_o);
      end
   endtask

   task automatic test_flush_reset();
      do_cycle(16'h0000, 1'b0, 1'b1);
      do_cycle(16'h0400, 1'b0, 1'b0);
      do_cycle(16'h0400, 1'b0, 1'b0);
      checks++;
      if (grant_oh_o !== 16'h0400 || coalesce_o !== 8'd1) begin
         errors++;
         $display("FAIL flush_setup: oh=%h coal=%0d expected oh=0400 coal=1", grant_oh_o, coalesce_o);
      end
      do_cycle(16'h0001, 1'b1, 1'b1);
      checks++;
      if (v_o !== 1'b0 || pending_o !== 16'h0 || coalesce_o !== 8'h0 || grant_oh_o !== 16'h0) begin
         errors++;
         $display("FAIL flush_clear: v=%b pend=%h coal=%h oh=%h expected 0 0000 00 0000",
                  v_o, pending_o, coalesce_o, grant_oh_o);
      end
      do_cycle(16'h0400, 1'b0, 1'b0);
      do_cycle(16'h0400, 1'b0, 1'b0);
      do_cycle(16'h0000, 1'b0, 1'b0);
      reset_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if (v_o !== 1'b0 || pending_o !== 16'h0 || coalesce_o !== 8'h0 ||
          grant_oh_o !== 16'h0 || grant_id_o !== 4'h0) begin
         errors++;
         $display("FAIL async_reset: v=%b pend=%h coal=%h oh=%h id=%0d expected all zero",
                  v_o, pending_o, coalesce_o, grant_oh_o, grant_id_o);
      end
      @(negedge clk);
      reset_n = 1'b1;
      do_cycle(16'h0000, 1'b0, 1'b0);
      checks++;
      if (v_o !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_idle: v=%b expected 0", v_o);
      end
   endtask

   task automatic test_random();
      logic [15:0] s;
      logic        y;
      logic        f;
      for (int i = 0; i < 400; i++) begin
         checks++;
         if (v_o !== (m_grant() >= 0) || grant_oh_o !== m_oh() || grant_id_o !== m_id()) begin
            errors++;
            $display("FAIL rand_grant[%0d]: v=%b oh=%h id=%0d expected v=%b oh=%h id=%0d",
                     i, v_o, grant_oh_o, grant_id_o, (m_grant() >= 0), m_oh(), m_id());
         end
         checks++;
         if (pending_o !== m_pend || coalesce_o !== 8'(m_coal)) begin
            errors++;
            $display("FAIL rand_state[%0d]: pend=%h coal=%0d expected pend=%h coal=%0d",
                     i, pending_o, coalesce_o, m_pend, m_coal);
         end
         s = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0;
         y = (m_grant() >= 0) && ($urandom_range(0, 2) != 0);
         f = ($urandom_range(0, 60) == 0);
         do_cycle(s, y, f);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_drain_order();
      test_hold_freeze();
      test_rearm();
      test_saturate();
      test_flush_reset();
      apply_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
